// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64 opcode, funct3 and MEM-stage FSM definitions
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_t;

  // Access size is funct3[1:0] for both loads and stores.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case ({1'b0, sz})
      F3_SB:   return 8'h01;
      F3_SH:   return 8'h03;
      F3_SW:   return 8'h0F;
      F3_SD:   return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] sz);
    case ({1'b0, sz})
      F3_SB:   return 1'b0;
      F3_SH:   return addr_lo[0];
      F3_SW:   return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane alignment and load byte-lane extraction
module mem_align
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   load_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;

  assign shamt = {addr_lo, 3'b000};
  assign wdata = store_data << shamt;
  assign wstrb = size_mask(funct3[1:0]) << addr_lo;
  assign lane  = rdata >> shamt;

  always_comb begin
    load_data = lane;
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LH:   load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_LW:   load_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3_LWU:  load_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      F3_LD:   load_data = lane;
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// rtl/pipeline_mem_stage.sv - RV64 MEM stage: data-memory handshake FSM and MEM/WB register
module pipeline_mem_stage
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_EX,
  input  logic [XLEN-1:0]   alu_result_EX,
  input  logic [XLEN-1:0]   store_data_EX,
  input  logic [4:0]        rd_EX,
  input  logic [6:0]        opcode_EX,
  input  logic [2:0]        funct3_EX,
  input  logic [XLEN-1:0]   pc_EX,
  output logic              stall_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              valid_WB,
  output logic              reg_write_WB,
  output logic [4:0]        rd_WB,
  output logic [XLEN-1:0]   wb_data_WB,
  output logic [XLEN-1:0]   pc_WB,
  output logic              misalign_WB,
  output logic              bus_err_WB
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic is_load_ex, is_store_ex, is_mem_ex, misalign_ex, start_ex;
  logic timeout_hit, done;

  logic [2:0]      req_addr_lo, req_funct3;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_pc;
  logic            req_is_load;

  logic [2:0]        al_addr_lo, al_funct3;
  logic [XLEN-1:0]   al_wdata, al_load;
  logic [XLEN/8-1:0] al_wstrb;

  assign is_load_ex  = (opcode_EX == OPC_LOAD);
  assign is_store_ex = (opcode_EX == OPC_STORE);
  assign is_mem_ex   = is_load_ex || is_store_ex;
  assign misalign_ex = is_misaligned(alu_result_EX[2:0], funct3_EX[1:0]);
  assign start_ex    = valid_EX && is_mem_ex && !misalign_ex;

  assign timeout_hit = (state == ST_REQ) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
  assign done        = (state == ST_REQ) && (mem_ack || timeout_hit);
  assign mem_req     = (state == ST_REQ);

  // One aligner serves both phases: EX operands feed store lanes in IDLE,
  // the captured access feeds load extraction while in REQ.
  assign al_addr_lo = (state == ST_REQ) ? req_addr_lo : alu_result_EX[2:0];
  assign al_funct3  = (state == ST_REQ) ? req_funct3  : funct3_EX;

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .store_data (store_data_EX),
    .rdata      (mem_rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_load)
  );

  always_comb begin
    state_nxt = state;
    stall_MEM = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_MEM = start_ex;
        if (start_ex) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        stall_MEM = !done;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mem_we      <= 1'b0;
      mem_wstrb   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      req_addr_lo <= '0;
      req_funct3  <= '0;
      req_rd      <= '0;
      req_pc      <= '0;
      req_is_load <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start_ex) begin
        cnt         <= '0;
        mem_addr    <= {alu_result_EX[XLEN-1:3], 3'b000};
        mem_we      <= is_store_ex;
        mem_wstrb   <= is_store_ex ? al_wstrb : '0;
        mem_wdata   <= is_store_ex ? al_wdata : '0;
        req_addr_lo <= alu_result_EX[2:0];
        req_funct3  <= funct3_EX;
        req_rd      <= rd_EX;
        req_pc      <= pc_EX;
        req_is_load <= is_load_ex;
      end else if (done) begin
        mem_we    <= 1'b0;
        mem_wstrb <= '0;
      end else if (state == ST_REQ) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_WB     <= 1'b0;
      reg_write_WB <= 1'b0;
      misalign_WB  <= 1'b0;
      bus_err_WB   <= 1'b0;
      rd_WB        <= '0;
      wb_data_WB   <= '0;
      pc_WB        <= '0;
    end else begin
      valid_WB     <= 1'b0;
      reg_write_WB <= 1'b0;
      misalign_WB  <= 1'b0;
      bus_err_WB   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_EX && !start_ex) begin
            valid_WB   <= 1'b1;
            rd_WB      <= rd_EX;
            pc_WB      <= pc_EX;
            wb_data_WB <= alu_result_EX;
            if (is_mem_ex) misalign_WB <= 1'b1;
            else reg_write_WB <= (opcode_EX != OPC_BRANCH) && (rd_EX != 5'd0);
          end
        end
        ST_REQ: begin
          if (done) begin
            valid_WB <= 1'b1;
            rd_WB    <= req_rd;
            pc_WB    <= req_pc;
            if (timeout_hit) begin
              bus_err_WB <= 1'b1;
            end else begin
              if (req_is_load) wb_data_WB <= al_load;
              reg_write_WB <= req_is_load && (req_rd != 5'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
